// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
//   fetch_state_e  - fetch control state (HOLD, RUN, FLUSH)
//   fetch_entry_t  - one buffered instruction: fetched data plus its address
//   *_DEF          - default widths / buffer depth used by the fetch modules
package fetch_pkg;

  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int BUF_DEPTH_DEF  = 2;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] data;
    logic [ADDR_WIDTH_DEF-1:0] addr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: two-entry FIFO holding fetched instructions until the
// decode stage accepts them.
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   clear            - drop every stored entry at the next edge (wins over push)
//   push, push_entry - write one entry at the tail
//   head_valid       - an entry is available at the head
//   head_ready       - consumer takes the head entry when head_valid is high
//   head_entry       - current head entry
//   occupancy        - number of stored entries (0..2)
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  entry_t     push_entry,
  output logic       head_valid,
  input  logic       head_ready,
  output entry_t     head_entry,
  output logic [1:0] occupancy
);

  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       pop;

  assign head_valid = (count_q != 2'd0);
  assign head_entry = mem_q[rd_ptr_q];
  assign occupancy  = count_q;
  assign pop        = head_valid && head_ready;

  // Pointer/count update. The fetch credit rule keeps count_q + push - pop
  // within 0..2, so push never needs to be refused.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  // Storage is zeroed on reset so the head reads as zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: Hack fetch stage between the program counter and decode.
// Drives the ROM address from the PC, captures the synchronous ROM data one
// cycle later into a 2-entry skid buffer, and presents instructions to decode
// over a valid/ready handshake. Execute-stage redirects become a PC load and
// flush all wrong-path instructions.
// Ports:
//   clk, reset                   - rising-edge clock, synchronous active-high reset
//   pc_value                     - current PC
//   pc_increment, pc_load,
//   pc_load_value                - PC controls (never increment and load together)
//   rom_addr, rom_data           - instruction ROM (data one cycle after address)
//   redirect_valid, redirect_addr- jump request from execute
//   instr_valid, instr_ready,
//   instr_data, instr_addr       - instruction handshake to decode
// Optional build macro FETCH_PERF_EN adds fetch_count (accepted instructions)
// and stall_count (cycles valid but not ready), both saturating 16-bit.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_value,
  output logic                  pc_increment,
  output logic                  pc_load,
  output logic [ADDR_WIDTH-1:0] pc_load_value,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_addr
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]           fetch_count,
  output logic [15:0]           stall_count
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
  } entry_t;

  // The credit rule below is written for exactly two buffer entries.
  if (BUF_DEPTH != 2) begin : g_bad_depth
    $fatal(1, "instruction_fetch: BUF_DEPTH must be 2");
  end

  fetch_state_e          state_q, state_d;
  logic                  inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0] issue_addr_q, issue_addr_d;

  logic                  redirect;
  logic                  issue;
  logic                  buf_push;
  logic                  buf_valid;
  logic                  buf_pop;
  logic [1:0]            occupancy;
  logic [2:0]            credit_used;
  entry_t                push_entry;
  entry_t                head_entry;

  assign rom_addr = pc_value;
  assign redirect = redirect_valid && !reset;
  assign buf_pop  = buf_valid && instr_ready;

  // Slots that will still be taken after this edge's pop. Counting the pop
  // lets a fresh issue overlap a departing instruction, which is what
  // sustains one instruction per cycle while decode keeps accepting.
  assign credit_used = {1'b0, occupancy} + {2'b00, inflight_q} - {2'b00, buf_pop};
  assign issue = !reset && !redirect && (state_q == RUN) && (credit_used < 3'd2);

  // A redirect discards the outstanding ROM read instead of capturing it.
  assign buf_push   = inflight_q && !redirect;
  assign push_entry = '{data: rom_data, addr: issue_addr_q};

  fetch_skid_buffer #(
    .entry_t(entry_t)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect),
    .push      (buf_push),
    .push_entry(push_entry),
    .head_valid(buf_valid),
    .head_ready(instr_ready),
    .head_entry(head_entry),
    .occupancy (occupancy)
  );

  // Next state and PC control. A redirect takes priority from any state and
  // parks the fetch in FLUSH for one cycle while the PC takes the target.
  always_comb begin
    state_d      = state_q;
    inflight_d   = issue;
    issue_addr_d = issue ? pc_value : issue_addr_q;
    unique case (state_q)
      HOLD:    state_d = RUN;
      RUN:     state_d = RUN;
      FLUSH:   state_d = RUN;
      default: state_d = HOLD;
    endcase
    if (redirect) begin
      state_d = FLUSH;
    end
    pc_increment  = issue;
    pc_load       = redirect;
    pc_load_value = reset ? '0 : redirect_addr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HOLD;
      inflight_q   <= 1'b0;
      issue_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      inflight_q   <= inflight_d;
      issue_addr_q <= issue_addr_d;
    end
  end

  // Outputs are forced quiet during reset so decode never sees stale entries.
  assign instr_valid = buf_valid && !reset;
  assign instr_data  = reset ? '0 : head_entry.data;
  assign instr_addr  = reset ? '0 : head_entry.addr;

`ifdef FETCH_PERF_EN
  logic [15:0] fetch_count_q, fetch_count_d;
  logic [15:0] stall_count_q, stall_count_d;

  // Saturating counters of accepted instructions and back-pressure cycles.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (instr_valid && instr_ready && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
    if (instr_valid && !instr_ready && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= 16'd0;
      stall_count_q <= 16'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule
